// File: rtl/mult8b_rev_pkg.sv
// Shared types for the reversible-multiplier sequencer and its LIFO.
package mult8b_rev_pkg;

    localparam int unsigned OPND_W = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned GARB_W = 63;

    // One forward result: product plus the garbage needed to run the macro backwards.
    typedef struct packed {
        logic [PROD_W-1:0] p;
        logic [GARB_W-1:0] g;
    } rev_entry_t;

    typedef enum logic [2:0] {
        StIdle,
        StFwdRun,
        StFwdResp,
        StRevRun,
        StRevResp
    } seq_state_t;

endpackage

// File: rtl/mult8b_rev_lifo.sv
// Stack of forward results awaiting uncompute; top_o is the most recent un-popped push.
module mult8b_rev_lifo
    import mult8b_rev_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  rev_entry_t             push_data_i,
    input  logic                   pop_i,
    output rev_entry_t             top_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    rev_entry_t    mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_idx, top_idx;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o && !push_i;
    assign wr_idx  = count_q[AW-1:0];
    assign top_idx = wr_idx - AW'(1);
    assign top_o   = empty_o ? '0 : mem_q[top_idx];
    assign count_o = count_q;

    // Occupancy next state; a push takes precedence over a pop.
    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + CW'(1);
        end else if (do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Occupancy register; reset discards every stored entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage; slots at or above count_q are never read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

endmodule

// File: rtl/mult8b_rev_seq.sv
// Sequencer driving the reversible 8-bit multiplier: forward compute pushes {p,g},
// uncompute pops the top entry and replays it with dir=1 to recover A and B.
module mult8b_rev_seq
    import mult8b_rev_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fwd_valid,
    output logic                   fwd_ready,
    input  logic [OPND_W-1:0]      fwd_a,
    input  logic [OPND_W-1:0]      fwd_b,
    output logic                   p_valid,
    input  logic                   p_ready,
    output logic [PROD_W-1:0]      p_out,
    input  logic                   rev_valid,
    output logic                   rev_ready,
    output logic                   ab_valid,
    input  logic                   ab_ready,
    output logic [OPND_W-1:0]      a_out,
    output logic [OPND_W-1:0]      b_out,
    output logic [$clog2(DEPTH):0] depth_cnt,
    output logic                   m_dir,
    output logic [OPND_W-1:0]      m_f_a,
    output logic [OPND_W-1:0]      m_f_b,
    input  logic [PROD_W-1:0]      m_f_p,
    input  logic [GARB_W-1:0]      m_f_g,
    output logic [PROD_W-1:0]      m_r_p,
    output logic [GARB_W-1:0]      m_r_g,
    input  logic [OPND_W-1:0]      m_r_a,
    input  logic [OPND_W-1:0]      m_r_b
);

    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SettleLast = SW'(SETTLE - 1);

    seq_state_t        state_q, state_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic              dir_q, dir_d;
    logic [OPND_W-1:0] f_a_q, f_a_d, f_b_q, f_b_d;
    logic [PROD_W-1:0] r_p_q, r_p_d;
    logic [GARB_W-1:0] r_g_q, r_g_d;
    logic [PROD_W-1:0] p_q, p_d;
    logic [OPND_W-1:0] a_q, a_d, b_q, b_d;

    logic       lifo_push, lifo_pop, lifo_full, lifo_empty, rev_win;
    rev_entry_t push_entry, top_entry;

    assign push_entry = '{p: m_f_p, g: m_f_g};
    // Reverse wins a tie because it frees a slot.
    assign rev_win    = rev_valid && !lifo_empty;

    mult8b_rev_lifo #(
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (lifo_push),
        .push_data_i (push_entry),
        .pop_i       (lifo_pop),
        .top_o       (top_entry),
        .count_o     (depth_cnt),
        .full_o      (lifo_full),
        .empty_o     (lifo_empty)
    );

    // Next-state, handshake and macro-bus control; dir and buses always move on the same edge.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        dir_d     = dir_q;
        f_a_d     = f_a_q;
        f_b_d     = f_b_q;
        r_p_d     = r_p_q;
        r_g_d     = r_g_q;
        p_d       = p_q;
        a_d       = a_q;
        b_d       = b_q;
        fwd_ready = 1'b0;
        rev_ready = 1'b0;
        lifo_push = 1'b0;
        lifo_pop  = 1'b0;
        unique case (state_q)
            StIdle: begin
                rev_ready = !lifo_empty;
                fwd_ready = !lifo_full && !rev_win;
                if (rev_win) begin
                    state_d  = StRevRun;
                    settle_d = '0;
                    dir_d    = 1'b1;
                    f_a_d    = '0;
                    f_b_d    = '0;
                    r_p_d    = top_entry.p;
                    r_g_d    = top_entry.g;
                end else if (fwd_valid && fwd_ready) begin
                    state_d  = StFwdRun;
                    settle_d = '0;
                    dir_d    = 1'b0;
                    f_a_d    = fwd_a;
                    f_b_d    = fwd_b;
                    r_p_d    = '0;
                    r_g_d    = '0;
                end
            end
            StFwdRun: begin
                if (settle_q == SettleLast) begin
                    lifo_push = 1'b1;
                    p_d       = m_f_p;
                    state_d   = StFwdResp;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            StFwdResp: begin
                if (p_ready) begin
                    state_d = StIdle;
                    f_a_d   = '0;
                    f_b_d   = '0;
                end
            end
            StRevRun: begin
                if (settle_q == SettleLast) begin
                    lifo_pop = 1'b1;
                    a_d      = m_r_a;
                    b_d      = m_r_b;
                    state_d  = StRevResp;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            StRevResp: begin
                if (ab_ready) begin
                    state_d = StIdle;
                    dir_d   = 1'b0;
                    r_p_d   = '0;
                    r_g_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, macro-bus and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            settle_q <= '0;
            dir_q    <= 1'b0;
            f_a_q    <= '0;
            f_b_q    <= '0;
            r_p_q    <= '0;
            r_g_q    <= '0;
            p_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            dir_q    <= dir_d;
            f_a_q    <= f_a_d;
            f_b_q    <= f_b_d;
            r_p_q    <= r_p_d;
            r_g_q    <= r_g_d;
            p_q      <= p_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    assign p_valid  = (state_q == StFwdResp);
    assign ab_valid = (state_q == StRevResp);
    assign p_out    = p_q;
    assign a_out    = a_q;
    assign b_out    = b_q;
    assign m_dir    = dir_q;
    assign m_f_a    = f_a_q;
    assign m_f_b    = f_b_q;
    assign m_r_p    = r_p_q;
    assign m_r_g    = r_g_q;

endmodule

// File: tb/tb_mult8b_rev_seq.sv
// Bench for mult8b_rev_seq: behavioural macro + stack model, directed cases, random traffic.
module tb_mult8b_rev_seq;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          fwd_valid = 1'b0, rev_valid = 1'b0, p_ready = 1'b1, ab_ready = 1'b1;
    logic [7:0]    fwd_a = '0, fwd_b = '0;
    logic          fwd_ready, rev_ready, p_valid, ab_valid, m_dir;
    logic [15:0]   p_out, m_f_p, m_r_p;
    logic [7:0]    a_out, b_out, m_f_a, m_f_b, m_r_a, m_r_b;
    logic [62:0]   m_f_g, m_r_g;
    logic [CW-1:0] depth_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult8b_rev_seq #(
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fwd_valid (fwd_valid),
        .fwd_ready (fwd_ready),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .p_out     (p_out),
        .rev_valid (rev_valid),
        .rev_ready (rev_ready),
        .ab_valid  (ab_valid),
        .ab_ready  (ab_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .depth_cnt (depth_cnt),
        .m_dir     (m_dir),
        .m_f_a     (m_f_a),
        .m_f_b     (m_f_b),
        .m_f_p     (m_f_p),
        .m_f_g     (m_f_g),
        .m_r_p     (m_r_p),
        .m_r_g     (m_r_g),
        .m_r_a     (m_r_a),
        .m_r_b     (m_r_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mul(input logic [7:0] a, input logic [7:0] b);
        return 16'(a) * 16'(b);
    endfunction

    function automatic logic [62:0] garb(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [47:0] mix;
        p   = mul(a, b);
        mix = {p, p, p} ^ {a, b, a, b, a, b};
        return {a, b, mix[46:0]};
    endfunction

    // Macro stand-in: answers only after its inputs have been held SETTLE cycles,
    // only in the matching direction, and only with the other bus idle.
    logic [95:0] mac_key;
    logic [95:0] mac_prev = '0;
    int          mac_held = 0;
    logic        mac_ok, fwd_clean, rev_clean;
    assign mac_key   = {m_dir, m_f_a, m_f_b, m_r_p, m_r_g};
    assign mac_ok    = (mac_key == mac_prev) && (mac_held >= int'(SETTLE) - 1);
    assign fwd_clean = mac_ok && !m_dir && (m_r_p == '0) && (m_r_g == '0);
    assign rev_clean = mac_ok && m_dir && (m_f_a == '0) && (m_f_b == '0)
                       && (m_r_p == mul(m_r_g[62:55], m_r_g[54:47]))
                       && (m_r_g == garb(m_r_g[62:55], m_r_g[54:47]));
    assign m_f_p = fwd_clean ? mul(m_f_a, m_f_b) : 16'hDEAD;
    assign m_f_g = fwd_clean ? garb(m_f_a, m_f_b) : '1;
    assign m_r_a = rev_clean ? m_r_g[62:55] : 8'hEE;
    assign m_r_b = rev_clean ? m_r_g[54:47] : 8'hEE;

    always @(posedge clk) begin
        if (mac_key != mac_prev) mac_held <= 1;
        else if (mac_held < 1000) mac_held <= mac_held + 1;
        mac_prev <= mac_key;
    end

    // Transaction-level reference: a stack of operand pairs plus the op in flight.
    typedef enum int {MIdle, MFwd, MRev} mop_t;
    mop_t        m_op = MIdle;
    int          m_k = 0;
    logic [7:0]  m_a = '0, m_b = '0;
    logic [15:0] stk[$];

    always @(negedge clk) begin : cmp_blk
        int          n;
        logic [15:0] top;
        logic [63:0] e_fr, e_rr, e_pv, e_av, e_dir, e_fa, e_fb, e_rp, e_rg, e_dep;
        if (!rst_n) begin
            chk("rst_p_valid", p_valid, 0);
            chk("rst_ab_valid", ab_valid, 0);
            chk("rst_depth", depth_cnt, 0);
            chk("rst_m_dir", m_dir, 0);
            chk("rst_m_f", {m_f_a, m_f_b}, 0);
            chk("rst_m_r", {m_r_p, m_r_g}, 0);
            m_op = MIdle;
            stk.delete();
        end else begin
            n    = stk.size();
            top  = (n > 0) ? stk[n-1] : 16'h0;
            e_fr = 0; e_rr = 0; e_pv = 0; e_av = 0; e_dir = 0;
            e_fa = 0; e_fb = 0; e_rp = 0; e_rg = 0; e_dep = 64'(n);
            case (m_op)
                MIdle: begin
                    e_rr = 64'(n > 0);
                    e_fr = 64'((n < int'(DEPTH)) && !(rev_valid && n > 0));
                end
                MFwd: begin
                    e_fa = 64'(m_a);
                    e_fb = 64'(m_b);
                    if (m_k > int'(SETTLE)) begin
                        e_pv  = 1;
                        e_dep = 64'(n + 1);
                    end
                end
                default: begin
                    e_dir = 1;
                    e_rp  = 64'(mul(top[15:8], top[7:0]));
                    e_rg  = 64'(garb(top[15:8], top[7:0]));
                    if (m_k > int'(SETTLE)) begin
                        e_av  = 1;
                        e_dep = 64'(n - 1);
                    end
                end
            endcase
            chk("cyc_fwd_ready", fwd_ready, e_fr);
            chk("cyc_rev_ready", rev_ready, e_rr);
            chk("cyc_p_valid", p_valid, e_pv);
            chk("cyc_ab_valid", ab_valid, e_av);
            chk("cyc_depth", depth_cnt, e_dep);
            chk("cyc_m_dir", m_dir, e_dir);
            chk("cyc_m_f_a", m_f_a, e_fa);
            chk("cyc_m_f_b", m_f_b, e_fb);
            chk("cyc_m_r_p", m_r_p, e_rp);
            chk("cyc_m_r_g", m_r_g, e_rg);
            if (e_pv != 0) chk("cyc_p_out", p_out, 64'(mul(m_a, m_b)));
            if (e_av != 0) chk("cyc_ab_out", {a_out, b_out}, 64'(top));
            case (m_op)
                MIdle: begin
                    if (rev_valid && n > 0) begin
                        m_op = MRev;
                        m_k  = 1;
                    end else if (fwd_valid && n < int'(DEPTH)) begin
                        m_op = MFwd;
                        m_k  = 1;
                        m_a  = fwd_a;
                        m_b  = fwd_b;
                    end
                end
                MFwd: begin
                    if (m_k > int'(SETTLE) && p_ready) begin
                        stk.push_back({m_a, m_b});
                        m_op = MIdle;
                    end else m_k++;
                end
                default: begin
                    if (m_k > int'(SETTLE) && ab_ready) begin
                        void'(stk.pop_back());
                        m_op = MIdle;
                    end else m_k++;
                end
            endcase
        end
    end

    function automatic logic sig(input int which);
        case (which)
            0:       return fwd_ready;
            1:       return rev_ready;
            2:       return p_valid;
            default: return ab_valid;
        endcase
    endfunction

    // Waits (bounded) for a signal at negedges; lat counts negedges waited.
    task automatic wait_for(input int which, input string name, output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (sig(which)) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
        lat = -1;
    endtask

    task automatic fwd_op(input logic [7:0] a, input logic [7:0] b, input int stall,
                          output logic [15:0] p, output int lat, output logic dir1);
        int w;
        fwd_a = a; fwd_b = b; fwd_valid = 1'b1; p_ready = (stall == 0);
        wait_for(0, "fwd_accept", w);
        @(posedge clk); #1 fwd_valid = 1'b0;
        @(negedge clk);
        dir1 = m_dir;
        wait_for(2, "fwd_p_valid", lat);
        if (lat >= 0) lat++;
        p = p_out;
        for (int s = 0; s < stall; s++) begin
            chk("stall_p_valid", p_valid, 1);
            chk("stall_p_out", p_out, p);
            chk("stall_fwd_ready", fwd_ready, 0);
            @(negedge clk);
        end
        if (stall > 0) begin
            @(posedge clk); #1 p_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic rev_op(output logic [7:0] a, output logic [7:0] b, output int lat,
                          output logic dir1, output logic [15:0] rp1);
        int w;
        rev_valid = 1'b1; ab_ready = 1'b1;
        wait_for(1, "rev_accept", w);
        @(posedge clk); #1 rev_valid = 1'b0;
        @(negedge clk);
        dir1 = m_dir;
        rp1  = m_r_p;
        wait_for(3, "rev_ab_valid", lat);
        if (lat >= 0) lat++;
        a = a_out;
        b = b_out;
        @(posedge clk); #1;
    endtask

    initial begin : main
        logic [15:0] p, rp1;
        logic [7:0]  a, b;
        logic        dir1;
        int          lat;
        logic [15:0] ops[4];
        bit          seen;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("init_depth", depth_cnt, 0);
        chk("init_fwd_ready", fwd_ready, 1);
        chk("init_rev_ready", rev_ready, 0);
        @(posedge clk); #1;

        fwd_op(8'h0F, 8'h11, 0, p, lat, dir1);
        chk("fwd1_p", p, 16'h00FF);
        chk("fwd1_latency", lat, SETTLE + 1);
        chk("fwd1_dir", dir1, 0);
        chk("fwd1_depth", depth_cnt, 1);

        rev_op(a, b, lat, dir1, rp1);
        chk("rev1_dir", dir1, 1);
        chk("rev1_m_r_p", rp1, 16'h00FF);
        chk("rev1_ab", {a, b}, 16'h0F11);
        chk("rev1_latency", lat, SETTLE + 1);
        chk("rev1_depth", depth_cnt, 0);

        ops = '{16'h0305, 16'hFFFF, 16'h0007, 16'h0101};
        for (int i = 0; i < 4; i++) begin
            fwd_op(ops[i][15:8], ops[i][7:0], 0, p, lat, dir1);
            if (i == 0) chk("fwd_3x5", p, 16'h000F);
            if (i == 1) chk("fwd_255x255", p, 16'hFE01);
        end
        fwd_a = 8'h99; fwd_b = 8'h99; fwd_valid = 1'b1;
        @(negedge clk);
        chk("full_fwd_ready", fwd_ready, 0);
        chk("full_depth", depth_cnt, 4);
        @(posedge clk); #1 fwd_valid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            rev_op(a, b, lat, dir1, rp1);
            chk("lifo_order", {a, b}, ops[i]);
        end
        chk("drain_depth", depth_cnt, 0);

        fwd_a = 8'h09; fwd_b = 8'h0A; fwd_valid = 1'b1; rev_valid = 1'b1;
        @(negedge clk);
        chk("empty_rev_ready", rev_ready, 0);
        chk("empty_fwd_ready", fwd_ready, 1);
        @(posedge clk); #1 fwd_valid = 1'b0; rev_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("empty_no_ab", ab_valid, 0);
            if (p_valid) seen = 1'b1;
        end
        chk("empty_fwd_done", seen, 1);
        chk("empty_depth", depth_cnt, 1);
        @(posedge clk); #1;

        fwd_op(8'h21, 8'h42, 0, p, lat, dir1);
        chk("tie_pre_depth", depth_cnt, 2);
        fwd_a = 8'h33; fwd_b = 8'h44; fwd_valid = 1'b1; rev_valid = 1'b1;
        @(negedge clk);
        chk("tie_rev_ready", rev_ready, 1);
        chk("tie_fwd_ready", fwd_ready, 0);
        @(posedge clk); #1 rev_valid = 1'b0;
        wait_for(3, "tie_ab_valid", lat);
        chk("tie_ab", {a_out, b_out}, 16'h2142);
        chk("tie_mid_depth", depth_cnt, 1);
        wait_for(0, "tie_fwd_accept", lat);
        @(posedge clk); #1 fwd_valid = 1'b0;
        wait_for(2, "tie_p_valid", lat);
        chk("tie_p", p_out, 16'h0D8C);
        chk("tie_post_depth", depth_cnt, 2);
        @(posedge clk); #1;

        fwd_op(8'h12, 8'h34, 5, p, lat, dir1);
        chk("stall_p", p, 16'h03A8);
        chk("stall_depth", depth_cnt, 3);

        rev_valid = 1'b1;
        wait_for(1, "rst_rev_accept", lat);
        @(posedge clk); #1 rev_valid = 1'b0;
        @(negedge clk);
        chk("revrun_m_dir", m_dir, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_depth", depth_cnt, 0);
        chk("arst_m_dir", m_dir, 0);
        chk("arst_valids", {p_valid, ab_valid}, 0);
        chk("arst_m_r", {m_r_p, m_r_g}, 0);
        chk("arst_outs", {p_out, a_out, b_out}, 0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_ab", ab_valid, 0);
        end

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst_n     = (c != 1500);
            fwd_valid = 1'($urandom_range(0, 1));
            fwd_a     = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            fwd_b     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rev_valid = ($urandom_range(0, 9) < 4);
            p_ready   = ($urandom_range(0, 3) != 0);
            ab_ready  = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; fwd_valid = 1'b0; rev_valid = 1'b0; p_ready = 1'b1; ab_ready = 1'b1;
        repeat (10) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
